io_issue_buffer: RTL and testbench
==================================

// Module: io_issue_buffer
// PURPOSE
//  In-order holding buffer for IO-class ops. Sits between dispatch and io_unit.
//  IO ops have side effects (flag read, console print), so they never execute
//  speculatively. Each op waits here until its ROB tag is the ROB head. The
//  buffer then issues it to io_unit with a one-cycle retire strobe and reports
//  completion back to the ROB.
// PARAMETERS
//  DEPTH      4  number of buffered IO ops; power of two, >= 2
//  TAG_WIDTH  5  ROB tag width
// PORTS
//  clk              in   1          clock
//  rst              in   1          reset, synchronous, active-high
//  enq_valid_i      in   1          dispatch presents an IO op
//  enq_ready_o      out  1          buffer can accept; = (count < DEPTH)
//  enq_op_i         in   op_t       op to buffer
//  enq_tag_i        in   TAG_WIDTH  ROB tag of the op
//  enq_cpl_i        in   1          privilege at dispatch: 0=USER, 1=SUPERVISOR
//  rob_head_valid_i in   1          ROB head entry is valid
//  rob_head_tag_i   in   TAG_WIDTH  tag of the ROB head entry
//  flush_i          in   1          pipeline squash of all speculative ops
//  op_spec_o        out  op_t       op presented to io_unit (registered)
//  cpl_o            out  1          privilege presented to io_unit (registered)
//  retire_o         out  1          one-cycle strobe to io_unit
//  done_i           in   1          io_unit done
//  cmpl_valid_o     out  1          one-cycle completion pulse to the ROB
//  cmpl_tag_o       out  TAG_WIDTH  tag of the completed op
// BEHAVIOUR
//  - Storage: circular FIFO with rd_ptr, wr_ptr and count ($clog2(DEPTH+1) bits).
//    Pointers wrap modulo DEPTH.
//  - Enqueue: an entry is written when enq_valid_i && enq_ready_o && !flush_i.
//    When flush_i is high, enqueue is dropped.
//  - enq_ready_o is driven from the current count. A pop in COMPLETE frees the
//    slot only from the next cycle.
//  - FSM states: IDLE, FIRE, WAIT, COMPLETE.
//    - IDLE -> FIRE when all hold: count>0, rob_head_valid_i,
//      FIFO-head tag == rob_head_tag_i (exact TAG_WIDTH compare), !flush_i.
//      On this transition, head op and cpl are latched into op_spec_o / cpl_o.
//    - FIRE: retire_o=1 for exactly this cycle; go to WAIT.
//    - WAIT: stay until done_i; then go to COMPLETE.
//    - COMPLETE: cmpl_valid_o=1, cmpl_tag_o = latched tag; pop head
//      (rd_ptr+1, count-1); go to IDLE.
//  - Minimum latency from a head-tag match in IDLE: retire_o 1 cycle later,
//    cmpl_valid_o 3 cycles later (done_i=1).
//  - Back-to-back IO ops: the next op may enter FIRE no earlier than the cycle
//    after COMPLETE.
//  - flush_i in IDLE: clear count and set wr_ptr=rd_ptr. No retire is issued.
//  - flush_i in FIRE/WAIT/COMPLETE: the in-flight op is non-speculative (it is
//    the ROB head), so it finishes normally. All entries younger than it are
//    squashed: count becomes 1 and wr_ptr=rd_ptr+1; the pop in COMPLETE then
//    leaves count 0.
//  - Same-cycle enqueue and pop: both take effect; count is unchanged.
//  - Privilege is not checked here. cpl_o is forwarded and io_unit enforces it.
//  - Reset: state=IDLE, pointers/count=0.
//    Outputs: retire_o=0, cmpl_valid_o=0, cmpl_tag_o=0, op_spec_o='0, cpl_o=0.
//    enq_ready_o=1 from the first cycle after reset.
//    Reset mid-operation drops the in-flight op: no retire_o and no
//    cmpl_valid_o afterwards.
// TESTING
//  1. Enqueue tag 3, cpl=1, rob_head tag 3 valid, done_i=1
//     -> retire_o high exactly 1 cycle with cpl_o=1; cmpl_valid_o 2 cycles
//        later with cmpl_tag_o=3; count 0.
//  2. Enqueue tags 1,2,3,4 with the ROB head held at 0
//     -> enq_ready_o=0 after the 4th; a 5th enqueue is ignored; no retire_o.
//  3. Two entries (tags 5,6); ROB head steps 5 then 6
//     -> two retire strobes in tag order; cmpl_tag_o 5 then 6;
//        no overlapping FIRE.
//  4. Three entries, flush_i in IDLE
//     -> count 0, enq_ready_o=1, retire_o never asserts for the flushed tags.
//  5. Entries tags 7,8; flush_i on the FIRE cycle of tag 7
//     -> cmpl_valid_o for tag 7 only; tag 8 never retires; count 0.
//  6. rst asserted during WAIT
//     -> next cycle all outputs 0, no cmpl_valid_o, enq_ready_o=1.
//  7. Fill to DEPTH, then enqueue on the same cycle as the COMPLETE pop
//     -> that enqueue is refused; an enqueue on the next cycle is accepted.

Source files
------------

// File: rtl/io_issue_buffer.sv
// In-order holding buffer for IO-class ops. Each op waits until its ROB tag is
// the ROB head, then issues to io_unit with a retire strobe and reports completion.
module io_issue_buffer #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 5,
  parameter int OP_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  input  logic [OP_WIDTH-1:0]  enq_op_i,
  input  logic [TAG_WIDTH-1:0] enq_tag_i,
  input  logic                 enq_cpl_i,
  input  logic                 rob_head_valid_i,
  input  logic [TAG_WIDTH-1:0] rob_head_tag_i,
  input  logic                 flush_i,
  output logic [OP_WIDTH-1:0]  op_spec_o,
  output logic                 cpl_o,
  output logic                 retire_o,
  input  logic                 done_i,
  output logic                 cmpl_valid_o,
  output logic [TAG_WIDTH-1:0] cmpl_tag_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, COMPLETE} state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [OP_WIDTH-1:0]  op_mem  [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic                 cpl_mem [DEPTH];

  logic [OP_WIDTH-1:0]  op_spec_q;
  logic                 cpl_q;
  logic                 retire_q;
  logic                 cmpl_valid_q;
  logic [TAG_WIDTH-1:0] cmpl_tag_q;

  logic do_enq;
  logic do_pop;
  logic head_match;

  assign enq_ready_o = (cnt_q < CNT_W'(DEPTH));
  assign do_enq      = enq_valid_i && enq_ready_o && !flush_i;
  assign do_pop      = (state_q == COMPLETE);
  assign head_match  = (cnt_q != '0) && rob_head_valid_i &&
                       (tag_mem[rd_ptr_q] == rob_head_tag_i) && !flush_i;

  // A flush while an op is in flight keeps only that op (the FIFO head).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      if (state_q == IDLE) begin
        wr_ptr_d = rd_ptr_q;
        cnt_d    = '0;
      end else begin
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d    = CNT_W'(1);
        if (do_pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          cnt_d    = '0;
        end
      end
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_enq, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      op_mem[wr_ptr_q]  <= enq_op_i;
      tag_mem[wr_ptr_q] <= enq_tag_i;
      cpl_mem[wr_ptr_q] <= enq_cpl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      op_spec_q    <= '0;
      cpl_q        <= 1'b0;
      retire_q     <= 1'b0;
      cmpl_valid_q <= 1'b0;
      cmpl_tag_q   <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      retire_q     <= 1'b0;
      cmpl_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (head_match) begin
            state_q    <= FIRE;
            retire_q   <= 1'b1;
            op_spec_q  <= op_mem[rd_ptr_q];
            cpl_q      <= cpl_mem[rd_ptr_q];
            cmpl_tag_q <= tag_mem[rd_ptr_q];
          end
        end
        FIRE: state_q <= WAIT;
        WAIT: begin
          if (done_i) begin
            state_q      <= COMPLETE;
            cmpl_valid_q <= 1'b1;
          end
        end
        COMPLETE: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign op_spec_o    = op_spec_q;
  assign cpl_o        = cpl_q;
  assign retire_o     = retire_q;
  assign cmpl_valid_o = cmpl_valid_q;
  assign cmpl_tag_o   = cmpl_tag_q;

endmodule

// File: tb/tb_io_issue_buffer.sv
// Directed bench for io_issue_buffer: issue ordering, flush, reset and full-buffer cases.
module tb_io_issue_buffer;

  localparam int DEPTH = 4;
  localparam int TW    = 5;
  localparam int OW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid;
  logic          enq_ready;
  logic [OW-1:0] enq_op;
  logic [TW-1:0] enq_tag;
  logic          enq_cpl;
  logic          rob_head_valid;
  logic [TW-1:0] rob_head_tag;
  logic          flush;
  logic [OW-1:0] op_spec;
  logic          cpl;
  logic          retire;
  logic          done;
  logic          cmpl_valid;
  logic [TW-1:0] cmpl_tag;

  int checks = 0;
  int errors = 0;
  int log_q[$];

  always #5 clk = ~clk;

  io_issue_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_op_i(enq_op),
    .enq_tag_i(enq_tag), .enq_cpl_i(enq_cpl),
    .rob_head_valid_i(rob_head_valid), .rob_head_tag_i(rob_head_tag),
    .flush_i(flush), .op_spec_o(op_spec), .cpl_o(cpl), .retire_o(retire),
    .done_i(done), .cmpl_valid_o(cmpl_valid), .cmpl_tag_o(cmpl_tag)
  );

  // Event log: retire -> 100+op, completion -> tag
  always @(negedge clk) begin
    if (retire)     log_q.push_back(100 + int'(op_spec));
    if (cmpl_valid) log_q.push_back(int'(cmpl_tag));
  end

  function automatic logic [63:0] pack_log();
    logic [63:0] v = '0;
    foreach (log_q[i]) v = (v << 8) | 64'(log_q[i] & 8'hFF);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enq_valid = 1'b0; enq_op = '0; enq_tag = '0; enq_cpl = 1'b0;
    rob_head_valid = 1'b0; rob_head_tag = '0; flush = 1'b0; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic enq(input logic [TW-1:0] t, input logic c);
    enq_valid = 1'b1; enq_tag = t; enq_op = OW'(t); enq_cpl = c;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wait_cmpl(output logic [TW-1:0] t, output bit ok);
    ok = 1'b0; t = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmpl_valid) begin ok = 1'b1; t = cmpl_tag; return; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({retire, cmpl_valid, cmpl_tag, op_spec, cpl} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", {retire, cmpl_valid, cmpl_tag, op_spec, cpl});
    end
    checks++;
    if (enq_ready !== 1'b1 || dut.cnt_q !== 3'd0) begin
      errors++; $display("FAIL reset_ready got rdy=%b cnt=%0d want rdy=1 cnt=0", enq_ready, dut.cnt_q);
    end
  endtask

  task automatic test_single();
    do_reset();
    rob_head_valid = 1'b1; rob_head_tag = 5'd3; done = 1'b1;
    enq(5'd3, 1'b1);
    checks++;
    if (retire !== 1'b0) begin errors++; $display("FAIL single_pre_retire got=%b want=0", retire); end
    tick();
    checks++;
    if (retire !== 1'b1 || cpl !== 1'b1 || op_spec !== 8'd3) begin
      errors++; $display("FAIL single_fire got ret=%b cpl=%b op=%h want 1 1 03", retire, cpl, op_spec);
    end
    tick();
    checks++;
    if (retire !== 1'b0 || cmpl_valid !== 1'b0) begin
      errors++; $display("FAIL single_wait got ret=%b cmpl=%b want 0 0", retire, cmpl_valid);
    end
    tick();
    checks++;
    if (cmpl_valid !== 1'b1 || cmpl_tag !== 5'd3) begin
      errors++; $display("FAIL single_cmpl got v=%b tag=%0d want 1 3", cmpl_valid, cmpl_tag);
    end
    tick();
    checks++;
    if (cmpl_valid !== 1'b0 || dut.cnt_q !== 3'd0 || log_q.size() != 2) begin
      errors++; $display("FAIL single_after got v=%b cnt=%0d log=%0d want 0 0 2", cmpl_valid, dut.cnt_q, log_q.size());
    end
  endtask

  task automatic test_full();
    logic [TW-1:0] t;
    bit ok;
    do_reset();
    rob_head_valid = 1'b1; rob_head_tag = 5'd0; done = 1'b1;
    for (int i = 1; i <= 4; i++) enq(TW'(i), 1'b0);
    checks++;
    if (enq_ready !== 1'b0 || dut.cnt_q !== 3'd4) begin
      errors++; $display("FAIL full_ready got rdy=%b cnt=%0d want 0 4", enq_ready, dut.cnt_q);
    end
    enq(5'd5, 1'b0);
    tick(); tick();
    checks++;
    if (dut.cnt_q !== 3'd4 || log_q.size() != 0) begin
      errors++; $display("FAIL full_fifth got cnt=%0d log=%0d want 4 0", dut.cnt_q, log_q.size());
    end
    for (int i = 1; i <= 4; i++) begin
      rob_head_tag = TW'(i);
      wait_cmpl(t, ok);
      checks++;
      if (!ok || t !== TW'(i)) begin
        errors++; $display("FAIL full_drain got ok=%0d tag=%0d want 1 %0d", ok, t, i);
      end
    end
    tick();
    checks++;
    if (dut.cnt_q !== 3'd0 || log_q.size() != 8 || pack_log() !== 64'h6501660267036804) begin
      errors++; $display("FAIL full_log got cnt=%0d log=%h want 0 6501660267036804", dut.cnt_q, pack_log());
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] t;
    bit ok;
    do_reset();
    done = 1'b1;
    enq(5'd5, 1'b0);
    enq(5'd6, 1'b1);
    rob_head_valid = 1'b1; rob_head_tag = 5'd5;
    wait_cmpl(t, ok);
    checks++;
    if (!ok || t !== 5'd5) begin errors++; $display("FAIL b2b_first got ok=%0d tag=%0d want 1 5", ok, t); end
    rob_head_tag = 5'd6;
    wait_cmpl(t, ok);
    checks++;
    if (!ok || t !== 5'd6) begin errors++; $display("FAIL b2b_second got ok=%0d tag=%0d want 1 6", ok, t); end
    tick(); tick();
    checks++;
    if (log_q.size() != 4 || pack_log() !== 64'h69056A06 || dut.cnt_q !== 3'd0) begin
      errors++; $display("FAIL b2b_order got log=%h cnt=%0d want 69056a06 0", pack_log(), dut.cnt_q);
    end
  endtask

  task automatic test_flush_idle();
    logic [TW-1:0] t;
    bit ok;
    do_reset();
    done = 1'b1;
    enq(5'd1, 1'b0); enq(5'd2, 1'b0); enq(5'd3, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dut.cnt_q !== 3'd0 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_cnt got cnt=%0d rdy=%b want 0 1", dut.cnt_q, enq_ready);
    end
    rob_head_valid = 1'b1; rob_head_tag = 5'd1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (log_q.size() != 0) begin errors++; $display("FAIL flush_idle_noret got log=%0d want 0", log_q.size()); end
    enq(5'd9, 1'b0);
    rob_head_tag = 5'd9;
    wait_cmpl(t, ok);
    tick();
    checks++;
    if (!ok || log_q.size() != 2 || pack_log() !== 64'h6D09) begin
      errors++; $display("FAIL flush_idle_reuse got ok=%0d log=%h want 1 6d09", ok, pack_log());
    end
  endtask

  task automatic test_flush_fire();
    logic [TW-1:0] t;
    bit ok;
    do_reset();
    enq(5'd7, 1'b0);
    enq(5'd8, 1'b0);
    rob_head_valid = 1'b1; rob_head_tag = 5'd7;
    tick();
    checks++;
    if (retire !== 1'b1) begin errors++; $display("FAIL flush_fire_ret got=%b want 1", retire); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dut.cnt_q !== 3'd1) begin errors++; $display("FAIL flush_fire_cnt got=%0d want 1", dut.cnt_q); end
    done = 1'b1;
    wait_cmpl(t, ok);
    checks++;
    if (!ok || t !== 5'd7) begin errors++; $display("FAIL flush_fire_cmpl got ok=%0d tag=%0d want 1 7", ok, t); end
    tick();
    rob_head_tag = 5'd8;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (dut.cnt_q !== 3'd0 || log_q.size() != 2 || pack_log() !== 64'h6B07) begin
      errors++; $display("FAIL flush_fire_log got cnt=%0d log=%h want 0 6b07", dut.cnt_q, pack_log());
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    rob_head_valid = 1'b1; rob_head_tag = 5'd2;
    enq(5'd2, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({retire, cmpl_valid, cmpl_tag, op_spec, cpl} !== '0 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wait_out got=%h rdy=%b want 0 1", {retire, cmpl_valid, cmpl_tag, op_spec, cpl}, enq_ready);
    end
    rst = 1'b0;
    log_q.delete();
    done = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (log_q.size() != 0) begin errors++; $display("FAIL rst_wait_nocmpl got log=%0d want 0", log_q.size()); end
  endtask

  task automatic test_full_pop_enq();
    logic [TW-1:0] t;
    bit ok;
    do_reset();
    done = 1'b1;
    for (int i = 1; i <= 4; i++) enq(TW'(i), 1'b0);
    rob_head_valid = 1'b1; rob_head_tag = 5'd1;
    tick(); tick(); tick();
    checks++;
    if (cmpl_valid !== 1'b1 || enq_ready !== 1'b0) begin
      errors++; $display("FAIL fpe_complete got v=%b rdy=%b want 1 0", cmpl_valid, enq_ready);
    end
    enq_valid = 1'b1; enq_tag = 5'd10; enq_op = 8'd10;
    tick();
    checks++;
    if (dut.cnt_q !== 3'd3 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL fpe_refused got cnt=%0d rdy=%b want 3 1", dut.cnt_q, enq_ready);
    end
    enq_tag = 5'd11; enq_op = 8'd11;
    tick();
    enq_valid = 1'b0;
    checks++;
    if (dut.cnt_q !== 3'd4) begin errors++; $display("FAIL fpe_accept got cnt=%0d want 4", dut.cnt_q); end
    for (int i = 0; i < 4; i++) begin
      rob_head_tag = (i == 3) ? 5'd11 : TW'(i + 2);
      wait_cmpl(t, ok);
      checks++;
      if (!ok || t !== rob_head_tag) begin
        errors++; $display("FAIL fpe_drain got ok=%0d tag=%0d want 1 %0d", ok, t, rob_head_tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush_idle();
    test_flush_fire();
    test_reset_wait();
    test_full_pop_enq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
